rom_read_sequencer: RTL and testbench
=====================================

# rom_read_sequencer

Upstream stage of the ROM reader datapath. On a start pulse it sweeps every ROM address from 0 to 2^ADDR_WIDTH-1 and, for each address, drives the parallel ROM's chip/output enables. It waits a programmable access time, captures the data byte and hands it downstream over a valid/ready handshake. The current address is exported on `address_line` to drive the 7-segment address display stage.

## Interface
- ADDR_WIDTH, 9, ROM address width; also the width of `address_line`.
- DATA_WIDTH, 8, ROM data width.
- ACCESS_CYCLES, 4, number of clk cycles `rom_oe_n` is held low before data is sampled; legal range 1..255.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  sampled high in IDLE to begin a sweep; ignored in every other state.
- abort  in  1  sampled high in any busy state to terminate the sweep.
- rom_data  in  DATA_WIDTH  ROM data bus.
- rom_addr  out  ADDR_WIDTH  ROM address bus (registered).
- rom_ce_n  out  1  ROM chip enable, active-low.
- rom_oe_n  out  1  ROM output enable, active-low.
- address_line  out  ADDR_WIDTH  copy of `rom_addr` for the address display.
- data_out  out  DATA_WIDTH  captured byte.
- data_valid  out  1  `data_out` is valid.
- data_ready  in  1  downstream accepts; a transfer occurs when `data_valid & data_ready`.
- busy  out  1  high in SETUP, ACCESS and OUTPUT.
- done  out  1  one-cycle pulse after the last address has been transferred.

## Operation
- **Reset values** (when `reset`=0 at an edge): state IDLE, `rom_addr`=`address_line`=0, `rom_ce_n`=1, `rom_oe_n`=1, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0, access counter 0. Reset overrides everything, including mid-sweep.
- **State machine:** IDLE, SETUP, ACCESS, OUTPUT, DONE.
  - IDLE: `start`=1 → SETUP with `rom_addr`=0.
  - SETUP: `rom_ce_n`=0, `rom_oe_n`=1, address stable; lasts 1 cycle → ACCESS with counter cleared.
  - ACCESS: `rom_ce_n`=0, `rom_oe_n`=0. The counter increments each cycle. On the cycle where counter == ACCESS_CYCLES-1, `rom_data` is registered into `data_out` → OUTPUT.
  - OUTPUT: `rom_ce_n`=`rom_oe_n`=1, `data_valid`=1, and `data_out` is held until a transfer occurs.
    - On transfer, if `rom_addr` == 2^ADDR_WIDTH-1 → DONE, with `rom_addr` unchanged.
    - Otherwise `rom_addr`+1 → SETUP.
  - DONE: `done`=1 for exactly one cycle → IDLE. `rom_addr` and `address_line` keep the last address (511) until the next start.
- **abort**: sampled in SETUP, ACCESS or OUTPUT, it moves the block to IDLE on the next edge.
  - `rom_ce_n`/`rom_oe_n` go to 1, `data_valid` to 0, `done` stays 0, `rom_addr` keeps its value.
  - abort has priority over a simultaneous transfer: a byte presented in the same cycle is dropped.
- There is no address wrap. The sweep terminates at the maximum address, and the increment never overflows.
- `start` while busy or in DONE is ignored and does not restart the sweep.
- `data_valid` never deasserts without a transfer, except on abort or reset.
- `address_line` always equals `rom_addr`; there is no extra delay.

## Timing
- Reference edge E0 is the edge that samples `start`=1 in IDLE. SETUP for address 0 occupies the cycle after E0.
- Per address with `data_ready` held high: 1 (SETUP) + ACCESS_CYCLES + 1 (OUTPUT) = ACCESS_CYCLES+2 cycles.
- The address k SETUP cycle begins k·(ACCESS_CYCLES+2) cycles after E0.
- `done` is high in the cycle starting 2^ADDR_WIDTH·(ACCESS_CYCLES+2) cycles after E0. With defaults that is 3072 cycles.
- Each cycle with `data_valid`=1 and `data_ready`=0 extends the current address by one cycle.
- `rom_data` is sampled at the end of the last ACCESS cycle, i.e. after ACCESS_CYCLES full cycles with `rom_oe_n`=0.
- `rom_addr` changes only on the edge leaving OUTPUT, while `rom_ce_n` is already 1.

## Test plan
- **Full sweep:** ROM model returns addr[7:0]^8'h5A, `data_ready`=1, pulse `start` → exactly 512 transfers with `data_out` matching the model, in address order; `done` pulses once at cycle 3072 after E0; `address_line`=511 afterwards.
- **Backpressure:** hold `data_ready`=0 for 5 cycles at address 3 → `data_valid` and `data_out` stay stable, `rom_addr`=3, `rom_ce_n`=`rom_oe_n`=1; the address 4 SETUP starts one cycle after `data_ready` rises.
- **Reset mid-sweep:** assert `reset`=0 while in ACCESS at address 100 → next cycle all outputs are at reset values, state IDLE; a new `start` begins again at address 0.
- **abort:** pulse `abort` in OUTPUT at address 10 with `data_ready`=1 → no transfer counted, `data_valid`=0 and enables high next cycle, `done` never asserts, `address_line`=10.
- **start while busy:** pulse `start` at address 50 → the sweep continues unchanged and the total transfer count is 512.
- **ACCESS_CYCLES=1:** `rom_oe_n` is low for exactly 1 cycle per address and `done` appears at cycle 1536 after E0.

Source files
------------

// File: rtl/rom_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_read_sequencer
// Purpose  : Sweeps every address of a parallel ROM, drives its chip/output
//            enables, waits a programmable access time, captures each byte
//            and hands it downstream over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rom_read_sequencer #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    output logic [ADDR_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
);

    // Access counter is 8 bits wide: ACCESS_CYCLES is limited to 1..255.
    localparam int             CNT_W  = 8;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_OUTPUT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   data_q,  data_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;

    logic                    w_xfer;
    logic                    w_last_addr;

    assign w_xfer      = (state_q == S_OUTPUT) && data_ready;
    assign w_last_addr = &addr_q;

    // State, address, captured data and access counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort wins over a same-cycle transfer in any busy state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    addr_d  = '0;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == C_LAST) begin
                    data_d  = rom_data;
                    state_d = S_OUTPUT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_xfer) begin
                    // No wrap: the last address ends the sweep instead of incrementing.
                    if (w_last_addr) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + C_ADDR_ONE;
                        state_d = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: enables, handshake and status follow the current state.
    always_comb begin
        rom_ce_n   = 1'b1;
        rom_oe_n   = 1'b1;
        data_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_SETUP: begin
                rom_ce_n = 1'b0;
                busy     = 1'b1;
            end
            S_ACCESS: begin
                rom_ce_n = 1'b0;
                rom_oe_n = 1'b0;
                busy     = 1'b1;
            end
            S_OUTPUT: begin
                data_valid = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rom_addr     = addr_q;
    assign address_line = addr_q;
    assign data_out     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_read_sequencer
// Purpose  : Self-checking bench for rom_read_sequencer (vector table plus
//            directed multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_read_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, ACCESS_CYCLES = 4
    logic       reset, start, abort, data_ready;
    logic [8:0] rom_addr, address_line;
    logic [7:0] rom_data, data_out;
    logic       rom_ce_n, rom_oe_n, data_valid, busy, done;

    // Second instance, ACCESS_CYCLES = 1
    logic       reset1, start1, abort1, data_ready1;
    logic [8:0] rom_addr1, address_line1;
    logic [7:0] rom_data1, data_out1;
    logic       rom_ce_n1, rom_oe_n1, data_valid1, busy1, done1;

    // ROM model
    assign rom_data  = rom_addr[7:0]  ^ 8'h5A;
    assign rom_data1 = rom_addr1[7:0] ^ 8'h5A;

    rom_read_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .ACCESS_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rom_data(rom_data), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n),
        .rom_oe_n(rom_oe_n), .address_line(address_line), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
    );

    rom_read_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .abort(abort1),
        .rom_data(rom_data1), .rom_addr(rom_addr1), .rom_ce_n(rom_ce_n1),
        .rom_oe_n(rom_oe_n1), .address_line(address_line1), .data_out(data_out1),
        .data_valid(data_valid1), .data_ready(data_ready1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic       rst_n, st, ab, rdy;
        logic [8:0] addr;
        logic       ce_n, oe_n, valid, bsy, dn;
        logic [7:0] data;
    } vec_t;

    vec_t vt [13];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0, e1 = 0;
    int xfers = 0, base = 0;
    int done_cnt = 0, done_at = 0;
    int oe1_low = 0, x1 = 0, d1_cnt = 0, d1_at = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Observes the current cycle with final inputs; runs on the falling edge.
    task automatic observe();
        logic [31:0] idx;
        if (reset && data_valid && data_ready && !abort) begin
            idx = xfers - base;
            chk("xfer_addr", {23'd0, rom_addr}, idx);
            chk("xfer_data", {24'd0, data_out}, {24'd0, idx[7:0] ^ 8'h5A});
            xfers++;
        end
        if (done) begin
            done_cnt++;
            done_at = cyc - e0;
        end
        if (!rom_oe_n1) oe1_low++;
        if (data_valid1 && data_ready1) x1++;
        if (done1) begin
            d1_cnt++;
            d1_at = cyc - e1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_outs(input string nm, input logic [8:0] a, input logic ce, input logic oe,
                            input logic v, input logic b, input logic d);
        chk({nm, "_addr"},  {23'd0, rom_addr}, {23'd0, a});
        chk({nm, "_aline"}, {23'd0, address_line}, {23'd0, a});
        chk({nm, "_ce_n"},  {31'd0, rom_ce_n}, {31'd0, ce});
        chk({nm, "_oe_n"},  {31'd0, rom_oe_n}, {31'd0, oe});
        chk({nm, "_valid"}, {31'd0, data_valid}, {31'd0, v});
        chk({nm, "_busy"},  {31'd0, busy}, {31'd0, b});
        chk({nm, "_done"},  {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        int n;
        int dsave;
        logic pulsed;

        //          rst st ab rdy addr ce oe v  b  d  data
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0, 9'd0, 1'b1,1'b1,1'b0,1'b0,1'b0, 8'h00};
        vt[1]  = '{1'b1,1'b1,1'b0,1'b0, 9'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, 8'h00};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b0, 9'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b0, 9'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b0, 9'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b0, 9'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00};
        vt[6]  = '{1'b1,1'b0,1'b0,1'b0, 9'd0, 1'b1,1'b1,1'b1,1'b1,1'b0, 8'h5A};
        vt[7]  = '{1'b1,1'b0,1'b0,1'b0, 9'd0, 1'b1,1'b1,1'b1,1'b1,1'b0, 8'h5A};
        vt[8]  = '{1'b1,1'b0,1'b0,1'b1, 9'd1, 1'b0,1'b1,1'b0,1'b1,1'b0, 8'h00};
        vt[9]  = '{1'b1,1'b0,1'b1,1'b1, 9'd1, 1'b1,1'b1,1'b0,1'b0,1'b0, 8'h00};
        vt[10] = '{1'b1,1'b1,1'b0,1'b0, 9'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, 8'h00};
        vt[11] = '{1'b1,1'b1,1'b0,1'b0, 9'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0, 9'd0, 1'b1,1'b1,1'b0,1'b0,1'b0, 8'h00};

        reset = 1'b0; start = 1'b0; abort = 1'b0; data_ready = 1'b0;
        reset1 = 1'b0; start1 = 1'b0; abort1 = 1'b0; data_ready1 = 1'b1;

        // ---- vector table: reset, first address timing, backpressure, abort, start-while-busy
        for (int i = 0; i < 13; i++) begin
            reset = vt[i].rst_n; start = vt[i].st; abort = vt[i].ab; data_ready = vt[i].rdy;
            step();
            chk_outs($sformatf("vec%0d", i), vt[i].addr, vt[i].ce_n, vt[i].oe_n,
                     vt[i].valid, vt[i].bsy, vt[i].dn);
            if (vt[i].valid) chk($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, vt[i].data});
        end
        start = 1'b0; abort = 1'b0;

        // ---- full sweep with a stray start at address 50
        reset = 1'b0; step(); reset = 1'b1;
        data_ready = 1'b1; start = 1'b1; base = xfers; dsave = done_cnt;
        step(); e0 = cyc; start = 1'b0;
        pulsed = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == dsave; i++) begin
            if (!pulsed && rom_addr == 9'd50 && busy) begin
                start = 1'b1; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("sweep_done_count", done_cnt - dsave, 1);
        chk("sweep_done_cycle", done_at, 3072);
        chk("sweep_xfers", xfers - base, 512);
        chk_outs("sweep_after", 9'd511, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        chk("sweep_done_once", done_cnt - dsave, 1);
        chk("sweep_aline_hold", {23'd0, address_line}, 511);

        // ---- backpressure at address 3
        reset = 1'b0; step(); reset = 1'b1;
        start = 1'b1; base = xfers; step(); start = 1'b0;
        for (int i = 0; i < 200 && !(rom_addr == 9'd3 && data_valid); i++) step();
        chk("bp_reach", {31'd0, (rom_addr == 9'd3 && data_valid)}, 1);
        data_ready = 1'b0;
        repeat (5) begin
            step();
            chk_outs("bp_hold", 9'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("bp_hold_data", {24'd0, data_out}, 32'h59);
        end
        data_ready = 1'b1;
        step();
        chk_outs("bp_setup4", 9'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 20 && !data_valid; i++) begin
            step();
            if (!rom_oe_n) n++;
        end
        chk("bp_oe_cycles", n, 4);
        chk("bp_data4", {24'd0, data_out}, 32'h5E);
        chk("bp_xfers", xfers - base, 4);

        // ---- reset while in ACCESS at address 100
        for (int i = 0; i < 1000 && !(rom_addr == 9'd100 && !rom_oe_n); i++) step();
        chk("rst_reach", {31'd0, (rom_addr == 9'd100 && !rom_oe_n)}, 1);
        reset = 1'b0; step();
        chk_outs("rst_mid", 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_data", {24'd0, data_out}, 0);
        reset = 1'b1; step();
        chk_outs("rst_idle", 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1; base = xfers; step(); start = 1'b0;
        chk_outs("rst_restart", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---- abort in OUTPUT at address 10 with data_ready high
        for (int i = 0; i < 200 && !(rom_addr == 9'd10 && data_valid); i++) step();
        chk("ab_reach", {31'd0, (rom_addr == 9'd10 && data_valid)}, 1);
        abort = 1'b1; dsave = done_cnt;
        step();
        abort = 1'b0;
        chk("ab_xfers", xfers - base, 10);
        chk_outs("ab_after", 9'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        chk("ab_no_done", done_cnt - dsave, 0);
        chk("ab_no_xfer", xfers - base, 10);
        chk("ab_aline", {23'd0, address_line}, 10);

        // ---- ACCESS_CYCLES = 1 instance
        reset1 = 1'b1; step();
        start1 = 1'b1; step(); e1 = cyc; start1 = 1'b0;
        oe1_low = 0; x1 = 0; d1_cnt = 0;
        for (int i = 0; i < 2000 && d1_cnt == 0; i++) step();
        chk("ac1_done_count", d1_cnt, 1);
        chk("ac1_done_cycle", d1_at, 1536);
        chk("ac1_oe_low", oe1_low, 512);
        chk("ac1_xfers", x1, 512);
        chk("ac1_aline", {23'd0, address_line1}, 511);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
